// File: rtl/exp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp_pkg
//  Description : Shared definitions for the a^n exponent controller.
//                Contents: the FSM state encoding, the iteration guard
//                (which equals the width of n), the iteration counter width,
//                and the datapath mux-select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package exp_pkg;

    // One iteration per bit of n; the guard equals the width of n.
    localparam int MAX_STEPS = 8;
    localparam int CNT_W     = 4;
    localparam int STATE_W   = 3;

    // Datapath mux selects: initial operand (a_i, n_i, 1) or feedback path.
    localparam logic SEL_INIT = 1'b0;
    localparam logic SEL_FB   = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        STEP  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } exp_state_t;

endpackage : exp_pkg
`default_nettype wire

// File: rtl/exp_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : exp_step_counter
//  Description : Saturating iteration counter for the exponent controller.
//                Clears on i_clr, increments on i_inc, and stops at
//                MAX_STEPS. o_at_limit tells the FSM to stop iterating, so a
//                faulty shifter can never keep the run going forever.
//  Ports       : clk, rst   - clock and synchronous active-high reset
//                i_clr      - clear the count to zero (wins over i_inc)
//                i_inc      - count one executed STEP
//                o_cnt      - current count (W bits)
//                o_at_limit - count has reached MAX_STEPS
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_step_counter #(
    parameter int MAX_STEPS = 8,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_at_limit
);

    localparam logic [W-1:0] C_LIMIT = W'(MAX_STEPS);

    logic [W-1:0] r_cnt;
    logic         w_at_limit;

    assign w_at_limit = (r_cnt >= C_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_at_limit = w_at_limit;

endmodule : exp_step_counter
`default_nettype wire

// File: rtl/exp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : exp_controller
//  Description : Control FSM that sequences the exponent datapath to compute
//                a^n by right-to-left square-and-multiply:
//                IDLE -> LOAD -> (CHECK -> STEP)* -> CHECK -> WRITE -> DONE.
//                Each STEP squares a, shifts n right by one bit, and, if
//                n[0] was set, multiplies result by the pre-square a.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start, abort       - run control from the front end
//                n_reg, n_grtr_0    - n register and its nonzero flag
//                sel_a_reg, sel_n_reg, sel_result_reg
//                                   - datapath mux selects (0 = initial value)
//                ld_a, ld_n, ld_result, ld_output
//                                   - datapath register load enables
//                busy, done         - status (done is a one-cycle pulse)
//                iter_cnt           - STEP cycles executed in this run
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_controller #(
    parameter int MAX_STEPS = exp_pkg::MAX_STEPS,
    parameter int CNT_W     = exp_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       n_reg,
    input  logic             n_grtr_0,
    output logic             sel_a_reg,
    output logic             sel_n_reg,
    output logic             sel_result_reg,
    output logic             ld_a,
    output logic             ld_n,
    output logic             ld_result,
    output logic             ld_output,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
);

    import exp_pkg::*;

    exp_state_t       r_state;

    logic             w_clr_cnt;
    logic             w_inc_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_at_limit;

    logic             w_sel;
    logic             w_ld_a;
    logic             w_ld_n;
    logic             w_ld_result;
    logic             w_ld_output;
    logic             w_busy;
    logic             w_done;

    // Only n[0] steers control; the upper bits feed the datapath shifter.
    logic             w_unused_n;
    assign w_unused_n = ^n_reg[7:1];

    // ------------------------------------------------------------------
    // Iteration counter: cleared when a run is accepted, counts STEPs.
    // ------------------------------------------------------------------
    assign w_clr_cnt = (r_state == IDLE) && start;
    assign w_inc_cnt = (r_state == STEP);

    exp_step_counter #(
        .MAX_STEPS (MAX_STEPS),
        .W         (CNT_W)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr_cnt),
        .i_inc      (w_inc_cnt),
        .o_cnt      (w_cnt),
        .o_at_limit (w_at_limit)
    );

    // ------------------------------------------------------------------
    // State register. abort is honoured only while the operands are being
    // consumed (LOAD/CHECK/STEP); once WRITE is reached the commit finishes.
    // start outside IDLE is dropped, not queued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) r_state <= LOAD;
                end
                LOAD: begin
                    r_state <= abort ? IDLE : CHECK;
                end
                CHECK: begin
                    if (abort)                        r_state <= IDLE;
                    else if (n_grtr_0 && !w_at_limit) r_state <= STEP;
                    else                              r_state <= WRITE;
                end
                STEP: begin
                    r_state <= abort ? IDLE : CHECK;
                end
                WRITE: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from state. Feedback is selected everywhere except
    // LOAD. In STEP the result register loads only when the current low
    // bit of n is set, multiplying by a before this step's squaring lands.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = SEL_FB;
        w_ld_a      = 1'b0;
        w_ld_n      = 1'b0;
        w_ld_result = 1'b0;
        w_ld_output = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
            end
            LOAD: begin
                w_sel       = SEL_INIT;
                w_ld_a      = 1'b1;
                w_ld_n      = 1'b1;
                w_ld_result = 1'b1;
            end
            CHECK: begin
            end
            STEP: begin
                w_ld_a      = 1'b1;
                w_ld_n      = 1'b1;
                w_ld_result = n_reg[0];
            end
            WRITE: begin
                w_ld_output = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // While reset is held every output reads zero, including the selects
    // that would otherwise idle at the feedback setting.
    assign sel_a_reg      = rst ? SEL_INIT : w_sel;
    assign sel_n_reg      = rst ? SEL_INIT : w_sel;
    assign sel_result_reg = rst ? SEL_INIT : w_sel;
    assign ld_a           = w_ld_a      & ~rst;
    assign ld_n           = w_ld_n      & ~rst;
    assign ld_result      = w_ld_result & ~rst;
    assign ld_output      = w_ld_output & ~rst;
    assign busy           = w_busy      & ~rst;
    assign done           = w_done      & ~rst;
    assign iter_cnt       = rst ? '0 : w_cnt;

endmodule : exp_controller
`default_nettype wire

// File: tb/tb_exp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_controller
//  Description : Self-checking bench for exp_controller. A behavioural
//                exponent datapath (a, n, result, output registers) is driven
//                by the controller's selects and loads; expected results,
//                latencies, counts and ld_result patterns come from a
//                constant vector table and are checked through a scoreboard
//                when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  n_reg;
    logic        n_grtr_0;
    logic        sel_a_reg, sel_n_reg, sel_result_reg;
    logic        ld_a, ld_n, ld_result, ld_output;
    logic        busy, done;
    logic [3:0]  iter_cnt;

    // Datapath model state and operand inputs
    logic [15:0] a_i;
    logic [7:0]  n_i;
    logic        frc_ng;
    logic [15:0] a_r   = 16'd0;
    logic [7:0]  n_r   = 8'd0;
    logic [15:0] res_r = 16'd0;
    logic [15:0] out_r = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  n;
        logic        frc;
        logic [15:0] res;
        int          lat;
        logic [3:0]  iter;
        logic [31:0] mask;   // cycles (relative to E0) in which ld_result is high
    } vec_t;

    typedef struct {
        int          e0;
        logic [15:0] res;
        int          lat;
        logic [3:0]  iter;
        logic [31:0] mask;
    } exp_t;

    vec_t        tbl[8];
    exp_t        q[$];
    exp_t        cur;
    logic [31:0] ldr_hist = 32'd0;
    int          rel;

    always #5 clk = ~clk;

    exp_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .n_reg          (n_reg),
        .n_grtr_0       (n_grtr_0),
        .sel_a_reg      (sel_a_reg),
        .sel_n_reg      (sel_n_reg),
        .sel_result_reg (sel_result_reg),
        .ld_a           (ld_a),
        .ld_n           (ld_n),
        .ld_result      (ld_result),
        .ld_output      (ld_output),
        .busy           (busy),
        .done           (done),
        .iter_cnt       (iter_cnt)
    );

    // Behavioural datapath, products truncated to 16 bits
    assign n_reg    = n_r;
    assign n_grtr_0 = frc_ng | (n_r != 8'd0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_a)      a_r   <= sel_a_reg      ? 16'(a_r * a_r)   : a_i;
        if (ld_n)      n_r   <= sel_n_reg      ? (n_r >> 1)       : n_i;
        if (ld_result) res_r <= sel_result_reg ? 16'(res_r * a_r) : 16'd1;
        if (ld_output) out_r <= res_r;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (q.size() == 0) begin
            check("spurious_done", {31'd0, done}, 32'd0);
        end else begin
            rel = cyc - q[0].e0 + 1;
            if (ld_result && rel >= 0 && rel < 32) ldr_hist[rel] = 1'b1;
            if (done) begin
                cur = q.pop_front();
                check("done_cycle",   rel,               cur.lat);
                check("output_reg",   {16'd0, out_r},    {16'd0, cur.res});
                check("iter_cnt",     {28'd0, iter_cnt}, {28'd0, cur.iter});
                check("ld_result_seq", ldr_hist,         cur.mask);
                ldr_hist = 32'd0;
            end
        end
        if (done) done_count++;
    end

    // Pulse start for one cycle from a negedge; E0 is the next posedge.
    task automatic start_run(input logic [15:0] a, input logic [7:0] n, input logic f,
                             input bit push, input exp_t e);
        exp_t ee;
        @(negedge clk);
        a_i    = a;
        n_i    = n;
        frc_ng = f;
        start  = 1'b1;
        if (push) begin
            ee    = e;
            ee.e0 = cyc + 1;
            q.push_back(ee);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    function automatic exp_t mk(input logic [15:0] res, input int lat,
                                input logic [3:0] iter, input logic [31:0] mask);
        exp_t e;
        e.e0 = 0; e.res = res; e.lat = lat; e.iter = iter; e.mask = mask;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ldo_seen, done_seen;
        int   dc0;

        tbl[0] = '{16'd3,     8'd5,   1'b0, 16'd243,   10, 4'd3, 32'h0000_008A};
        tbl[1] = '{16'd7,     8'd0,   1'b0, 16'd1,      4, 4'd0, 32'h0000_0002};
        tbl[2] = '{16'd2,     8'd15,  1'b0, 16'd32768, 12, 4'd4, 32'h0000_02AA};
        tbl[3] = '{16'd2,     8'd255, 1'b0, 16'd0,     20, 4'd8, 32'h0002_AAAA};
        tbl[4] = '{16'd9,     8'd0,   1'b1, 16'd1,     20, 4'd8, 32'h0000_0002};
        tbl[5] = '{16'd1,     8'd200, 1'b0, 16'd1,     20, 4'd8, 32'h0002_8202};
        tbl[6] = '{16'd5,     8'd2,   1'b0, 16'd25,     8, 4'd2, 32'h0000_0022};
        tbl[7] = '{16'hFFFF,  8'd3,   1'b0, 16'hFFFF,   8, 4'd2, 32'h0000_002A};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        a_i = 16'd0; n_i = 8'd0; frc_ng = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {19'd0, sel_a_reg, sel_n_reg, sel_result_reg, ld_a, ld_n, ld_result,
               ld_output, busy, done, iter_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {26'd0, ld_a, ld_n, ld_result, ld_output, busy, done}, 32'd0);

        // Table-driven runs
        for (int i = 0; i < 8; i++) begin
            start_run(tbl[i].a, tbl[i].n, tbl[i].frc, 1'b1,
                      mk(tbl[i].res, tbl[i].lat, tbl[i].iter, tbl[i].mask));
            wait_done("done_timeout");
            @(negedge clk);
            check("busy_fall", {31'd0, busy}, 32'd0);
        end
        frc_ng = 1'b0;

        // Abort in cycle 3 (first STEP) of an n=200 run
        start_run(16'd3, 8'd200, 1'b0, 1'b0, mk(16'd0, 0, 4'd0, 32'd0));
        @(negedge clk);                 // cycle 2
        @(negedge clk);                 // cycle 3
        abort = 1'b1;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);                 // cycle 4
        abort = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        ldo_seen = 1'b0; done_seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            ldo_seen |= ld_output;
            done_seen |= done;
        end
        check("abort_no_ld_output", {31'd0, ldo_seen}, 32'd0);
        check("abort_no_done",      {31'd0, done_seen}, 32'd0);
        check("abort_output_kept",  {16'd0, out_r}, 32'h0000_FFFF);

        // Normal run after abort
        start_run(16'd5, 8'd2, 1'b0, 1'b1, mk(16'd25, 8, 4'd2, 32'h0000_0022));
        wait_done("done_timeout_after_abort");
        @(negedge clk);

        // start pulses in cycles 2 and 6 are ignored
        dc0 = done_count;
        start_run(16'd3, 8'd5, 1'b0, 1'b1, mk(16'd243, 10, 4'd3, 32'h0000_008A));
        @(negedge clk); start = 1'b1;   // cycle 2
        @(negedge clk); start = 1'b0;   // cycle 3
        repeat (3) @(negedge clk);      // cycle 6
        start = 1'b1;
        @(negedge clk); start = 1'b0;   // cycle 7
        wait_done("done_timeout_start_ignored");
        repeat (25) @(negedge clk);
        check("single_done", done_count - dc0, 32'd1);

        // Reset asserted during a STEP cycle
        start_run(16'd3, 8'd5, 1'b0, 1'b0, mk(16'd0, 0, 4'd0, 32'd0));
        @(negedge clk);                 // cycle 2 (CHECK)
        @(negedge clk);                 // cycle 3 (STEP)
        check("step_ld_a", {31'd0, ld_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);                 // cycle 4
        check("rst_midrun_outputs",
              {22'd0, busy, done, ld_a, ld_n, ld_result, ld_output, iter_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_stays_idle", {31'd0, busy}, 32'd0);
        check("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exp_controller
`default_nettype wire
